// File: rtl/fpu_half_dispatch_pkg.sv
// Shared types for the half-precision FPU dispatch slice: operations, request payload, FSM encoding.
package fpu_half_dispatch_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned FPU_RD_W = 5;

  typedef enum logic [3:0] {
    FPU_HALF_ADD  = 4'd0,
    FPU_HALF_SUB  = 4'd1,
    FPU_HALF_MUL  = 4'd2,
    FPU_HALF_DIV  = 4'd3,
    FPU_HALF_SQRT = 4'd4,
    FPU_HALF_MIN  = 4'd5,
    FPU_HALF_MAX  = 4'd6,
    FPU_HALF_FEQ  = 4'd7,
    FPU_HALF_FLT  = 4'd8,
    FPU_HALF_FLE  = 4'd9
  } fpu_operation_t;

  typedef struct packed {
    fpu_operation_t      op;
    logic [WORD_W-1:0]   a;
    logic [WORD_W-1:0]   b;
    logic [FPU_RD_W-1:0] rd;
  } fpu_req_t;

  typedef enum logic [1:0] {
    DISP_IDLE = 2'd0,
    DISP_EXEC = 2'd1,
    DISP_WB   = 2'd2
  } fpu_disp_state_t;

endpackage

// File: rtl/fpu_half_dispatch_req_fifo.sv
// Request FIFO: wrapping pointers plus a separate occupancy count so full/empty never alias.
module fpu_req_fifo
  import fpu_half_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fpu_req_t,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           din,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers and count; flush empties the queue and drops any push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fpu_half_dispatch.sv
// Half-precision FPU dispatch: queues requests, runs the unit start/done handshake, holds results for writeback.
module fpu_half_dispatch
  import fpu_half_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RD_W  = FPU_RD_W,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  fpu_operation_t    req_op,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  input  logic [RD_W-1:0]   req_rd,
  output logic              fpu_start,
  output fpu_operation_t    fpu_operation,
  output logic [WORD_W-1:0] fpu_a,
  output logic [WORD_W-1:0] fpu_b,
  input  logic              fpu_done,
  input  logic [WORD_W-1:0] fpu_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [WORD_W-1:0] wb_data,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  localparam logic [1:0] ST_IDLE = DISP_IDLE;
  localparam logic [1:0] ST_EXEC = DISP_EXEC;
  localparam logic [1:0] ST_WB   = DISP_WB;

  logic [1:0]        state_q, state_d;
  logic              fpu_start_q, fpu_start_d;
  fpu_operation_t    fpu_op_q, fpu_op_d;
  logic [WORD_W-1:0] fpu_a_q, fpu_a_d;
  logic [WORD_W-1:0] fpu_b_q, fpu_b_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [WORD_W-1:0] wb_data_q, wb_data_d;

  fpu_req_t fifo_din, fifo_head;
  logic     fifo_full, fifo_empty, push, pop;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready && !flush;
  assign pop       = (state_q == ST_EXEC) && fpu_done && !flush;
  assign fifo_din  = '{op: req_op, a: req_a, b: req_b, rd: FPU_RD_W'(req_rd)};

  fpu_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fpu_req_t)
  ) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer next state, unit drive for the coming cycle, and writeback capture.
  always_comb begin
    state_d   = state_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_EXEC;
      ST_EXEC: begin
        if (fpu_done) begin
          state_d   = ST_WB;
          wb_data_d = fpu_out;
          wb_rd_d   = RD_W'(fifo_head.rd);
        end
      end
      ST_WB:   if (wb_ready) state_d = fifo_empty ? ST_IDLE : ST_EXEC;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
    end
    // Head cannot change while in EXEC (pop only on exit), so the unit sees stable operands.
    fpu_start_d = (state_d == ST_EXEC);
    fpu_op_d    = fpu_start_d ? fifo_head.op : fpu_operation_t'(4'd0);
    fpu_a_d     = fpu_start_d ? fifo_head.a : '0;
    fpu_b_d     = fpu_start_d ? fifo_head.b : '0;
    wb_valid_d  = (state_d == ST_WB);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      fpu_start_q <= 1'b0;
      fpu_op_q    <= fpu_operation_t'(4'd0);
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      fpu_start_q <= fpu_start_d;
      fpu_op_q    <= fpu_op_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign fpu_start     = fpu_start_q;
  assign fpu_operation = fpu_op_q;
  assign fpu_a         = fpu_a_q;
  assign fpu_b         = fpu_b_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign busy          = (state_q != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_fpu_half_dispatch.sv
// Directed bench for fpu_half_dispatch with a simple execution-unit stand-in.
module tb_fpu_half_dispatch;
  import fpu_half_dispatch_pkg::*;

  logic           CLK = 1'b0;
  logic           nRST;
  logic           flush;
  logic           req_valid;
  logic           req_ready;
  fpu_operation_t req_op;
  logic [31:0]    req_a, req_b;
  logic [4:0]     req_rd;
  logic           fpu_start;
  fpu_operation_t fpu_operation;
  logic [31:0]    fpu_a, fpu_b;
  logic           fpu_done;
  logic [31:0]    fpu_out;
  logic           wb_valid;
  logic           wb_ready;
  logic [4:0]     wb_rd;
  logic [31:0]    wb_data;
  logic           busy;
  logic [2:0]     count;

  // Unit stand-in: done follows start when enabled; result is either a fixed value or a + b.
  logic        done_en;
  logic        unit_sum;
  logic [31:0] unit_result;
  assign fpu_done = done_en & fpu_start;
  assign fpu_out  = unit_sum ? (fpu_a + fpu_b) : unit_result;

  int n_total = 0;
  int n_pass  = 0;

  fpu_half_dispatch #(.DEPTH(4), .RD_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .fpu_start(fpu_start), .fpu_operation(fpu_operation), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_out(fpu_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_req(input fpu_operation_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] exp_data [4];
    logic [4:0]  exp_rd   [4];
    int          k;

    exp_data = '{32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 32'h0000_0404};
    exp_rd   = '{5'd11, 5'd12, 5'd13, 5'd14};

    nRST = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = FPU_HALF_ADD;
    req_a = '0; req_b = '0; req_rd = '0; wb_ready = 1'b1;
    done_en = 1'b1; unit_sum = 1'b0; unit_result = '0;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fpu_start", 32'(fpu_start), 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    @(negedge CLK) nRST = 1'b1;
    tick;

    // 1: single half add, 1.0 + 2.0 = 3.0
    unit_result = 32'h0000_4200;
    set_req(FPU_HALF_ADD, 32'h0000_3C00, 32'h0000_4000, 5'd5);
    tick;
    req_valid = 1'b0;
    chk("t1_c0_start", 32'(fpu_start), 32'd0);
    chk("t1_c0_count", 32'(count), 32'd1);
    chk("t1_c0_busy", 32'(busy), 32'd1);
    tick;
    chk("t1_c1_start", 32'(fpu_start), 32'd1);
    chk("t1_c1_a", fpu_a, 32'h0000_3C00);
    chk("t1_c1_b", fpu_b, 32'h0000_4000);
    chk("t1_c1_op", 32'(fpu_operation), 32'(FPU_HALF_ADD));
    chk("t1_c1_wbv", 32'(wb_valid), 32'd0);
    tick;
    chk("t1_c2_wbv", 32'(wb_valid), 32'd1);
    chk("t1_c2_data", wb_data, 32'h0000_4200);
    chk("t1_c2_rd", 32'(wb_rd), 32'd5);
    chk("t1_c2_start", 32'(fpu_start), 32'd0);
    chk("t1_c2_count", 32'(count), 32'd0);
    tick;
    chk("t1_c3_wbv", 32'(wb_valid), 32'd0);
    chk("t1_c3_busy", 32'(busy), 32'd0);

    // 2: fill the queue behind a stalled unit, then drain in push order
    done_en = 1'b0; unit_sum = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(FPU_HALF_SUB, 32'(256 * (i + 1)), 32'(i + 1), 5'(11 + i));
      tick;
    end
    chk("t2_count_full", 32'(count), 32'd4);
    chk("t2_req_ready", 32'(req_ready), 32'd0);
    set_req(FPU_HALF_SUB, 32'h0000_0500, 32'd5, 5'd15);
    tick;
    req_valid = 1'b0;
    chk("t2_fifth_dropped", 32'(count), 32'd4);
    done_en = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      tick;
      if (wb_valid) begin
        chk("t2_wb_data", wb_data, exp_data[k]);
        chk("t2_wb_rd", 32'(wb_rd), 32'(exp_rd[k]));
        k++;
      end
    end
    chk("t2_results", 32'(k), 32'd4);
    tick;
    chk("t2_drained", 32'(count), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);

    // 3: writeback back-pressure holds the result and blocks the next issue
    wb_ready = 1'b0;
    set_req(FPU_HALF_MUL, 32'h0000_7000, 32'h0000_0011, 5'd9);
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    set_req(FPU_HALF_ADD, 32'h0000_0100, 32'h0000_0001, 5'd10);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_wbv", 32'(wb_valid), 32'd1);
      chk("t3_hold_data", wb_data, 32'h0000_7011);
      chk("t3_hold_rd", 32'(wb_rd), 32'd9);
      chk("t3_hold_start", 32'(fpu_start), 32'd0);
      tick;
      req_valid = 1'b0;
    end
    chk("t3_no_second_pop", 32'(count), 32'd1);
    wb_ready = 1'b1;
    tick;
    chk("t3_next_start", 32'(fpu_start), 32'd1);
    chk("t3_next_a", fpu_a, 32'h0000_0100);
    chk("t3_next_wbv", 32'(wb_valid), 32'd0);
    tick;
    chk("t3_next_data", wb_data, 32'h0000_0101);
    chk("t3_next_rd", 32'(wb_rd), 32'd10);
    tick;

    // 4: multi-cycle unit keeps start and operands steady
    done_en = 1'b0;
    set_req(FPU_HALF_MUL, 32'h0000_1234, 32'h0000_0002, 5'd3);
    tick;
    req_valid = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("t4_start", 32'(fpu_start), 32'd1);
      chk("t4_a", fpu_a, 32'h0000_1234);
      chk("t4_b", fpu_b, 32'h0000_0002);
      chk("t4_op", 32'(fpu_operation), 32'(FPU_HALF_MUL));
      if (i == 2) done_en = 1'b1;
      tick;
    end
    chk("t4_wbv", 32'(wb_valid), 32'd1);
    chk("t4_data", wb_data, 32'h0000_1236);
    chk("t4_rd", 32'(wb_rd), 32'd3);
    tick;

    // 5: flush during EXEC with work queued, a push and a done all in the flush cycle
    done_en = 1'b0;
    set_req(FPU_HALF_ADD, 32'h0000_0001, 32'h0000_0001, 5'd1);
    tick;
    set_req(FPU_HALF_ADD, 32'h0000_0002, 32'h0000_0002, 5'd2);
    tick;
    chk("t5_pre_count", 32'(count), 32'd2);
    chk("t5_pre_start", 32'(fpu_start), 32'd1);
    flush = 1'b1; done_en = 1'b1;
    set_req(FPU_HALF_ADD, 32'h0000_0003, 32'h0000_0003, 5'd3);
    tick;
    flush = 1'b0; req_valid = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_start", 32'(fpu_start), 32'd0);
    chk("t5_wbv", 32'(wb_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    tick;
    chk("t5_after_count", 32'(count), 32'd0);
    chk("t5_after_wbv", 32'(wb_valid), 32'd0);

    // 6: asynchronous reset while a result waits in WB, then a compare op
    wb_ready = 1'b0;
    set_req(FPU_HALF_ADD, 32'h0000_0001, 32'h0000_0002, 5'd7);
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("t6_wb_pending", 32'(wb_valid), 32'd1);
    set_req(FPU_HALF_ADD, 32'h0000_0010, 32'h0000_0020, 5'd8);
    tick;
    req_valid = 1'b0;
    chk("t6_queued", 32'(count), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("t6_rst_wbv", 32'(wb_valid), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_start", 32'(fpu_start), 32'd0);
    chk("t6_rst_wb_data", wb_data, 32'd0);
    @(negedge CLK) nRST = 1'b1;
    wb_ready = 1'b1;
    tick;
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    unit_sum = 1'b0; unit_result = 32'h0000_0001;
    set_req(FPU_HALF_FLT, 32'hFFFF_BC00, 32'hFFFF_3C00, 5'd12);
    tick;
    req_valid = 1'b0;
    tick;
    chk("t6_flt_op", 32'(fpu_operation), 32'(FPU_HALF_FLT));
    chk("t6_flt_a", fpu_a, 32'hFFFF_BC00);
    tick;
    chk("t6_flt_wbv", 32'(wb_valid), 32'd1);
    chk("t6_flt_data", wb_data, 32'h0000_0001);
    chk("t6_flt_rd", 32'(wb_rd), 32'd12);
    tick;
    chk("t6_final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
